// File: rtl/result_pkg.sv
// Shared widths, accumulator limits and the sign-magnitude to two's complement
// conversion used by the result collector.
package result_pkg;

  localparam int Y_W   = 13;
  localparam int D_W   = 14;
  localparam int ACC_W = 20;

  localparam logic signed [ACC_W-1:0] ACC_MAX = 20'sh7FFFF;
  localparam logic signed [ACC_W-1:0] ACC_MIN = 20'sh80000;

  // Negative zero falls out as zero because -0 == 0 in two's complement.
  function automatic logic [D_W-1:0] sm2tc(input logic [Y_W-1:0] y);
    logic [D_W-1:0] mag;
    mag = {2'b00, y[Y_W-2:0]};
    if (y[Y_W-1]) begin
      sm2tc = (~mag) + 14'd1;
    end else begin
      sm2tc = mag;
    end
  endfunction

endpackage

// File: rtl/result_fifo_core.sv
// Circular buffer for converted samples: storage, wrapping pointers and an
// occupancy count from which full/empty are derived.
module result_fifo_core #(
  parameter int DEPTH = 8,
  parameter int W     = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == {(AW+1){1'b0}});
  assign count = count_q;
  assign rdata = empty ? {W{1'b0}} : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: unread slots are masked by the empty check.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/result_collector.sv
// Converts the sign-magnitude result stream, buffers it and flags drops.
// Optional saturating running sum of accepted samples under RESULT_ACC_EN.
module result_collector
  import result_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [Y_W-1:0]         in_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [D_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [ACC_W-1:0]       acc
);

  logic           full_s, empty_s;
  logic           push_s, pop_s, drop_s;
  logic [D_W-1:0] conv_s;
  logic           overflow_q, overflow_d;

  assign conv_s = sm2tc(in_y);

  // A full buffer still accepts a sample when the head leaves in the same cycle.
  assign pop_s  = ~empty_s & out_ready & ~clr;
  assign push_s = in_valid & ~clr & (~full_s | (~empty_s & out_ready));
  assign drop_s = in_valid & ~clr & full_s & ~out_ready;

  result_fifo_core #(
    .DEPTH (DEPTH),
    .W     (D_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clr),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (conv_s),
    .rdata (out_data),
    .count (count),
    .full  (full_s),
    .empty (empty_s)
  );

  assign out_valid = ~empty_s;
  assign overflow  = overflow_q;

  always_comb begin
    overflow_d = overflow_q;
    if (clr) begin
      overflow_d = 1'b0;
    end else if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

`ifdef RESULT_ACC_EN
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum_s;

  assign sum_s = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-D_W){conv_s[D_W-1]}}, conv_s};

  // Sign disagreement between the two top sum bits means the 20-bit range was left.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = {ACC_W{1'b0}};
    end else if (push_s) begin
      if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
        acc_d = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_d = sum_s[ACC_W-1:0];
      end
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= {ACC_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;
`else
  assign acc = {ACC_W{1'b0}};
`endif

endmodule

// File: tb/tb_result_collector.sv
// Randomised bench for result_collector against a queue-based reference model,
// plus literal expectations for the directed scenarios.
module tb_result_collector;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [12:0] in_y = 13'd0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [13:0] out_data;
  logic [3:0]  count;
  logic        overflow;
  logic [19:0] acc;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  int q[$];
  bit m_ovf = 1'b0;
  int m_acc = 0;

  result_collector #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  function automatic int conv(input logic [12:0] y);
    int m;
    m = int'(y[11:0]);
    return y[12] ? -m : m;
  endfunction

  function automatic int sat(input int v);
    if (v > 524287) return 524287;
    if (v < -524288) return -524288;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("count", int'(count), q.size());
      chk("out_valid", int'(out_valid), int'(q.size() > 0));
      chk("out_data", int'($signed(out_data)), (q.size() > 0) ? q[0] : 0);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("acc", int'($signed(acc)), m_acc);
    end
  end

  task automatic model_update(input bit v, input logic [12:0] y, input bit rdy, input bit c);
    bit pop;
    bit push;
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_acc = 0;
    end else begin
      pop  = (q.size() > 0) && rdy;
      push = v && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(conv(y));
`ifdef RESULT_ACC_EN
        m_acc = sat(m_acc + conv(y));
`endif
      end
      if (v && !push) m_ovf = 1'b1;
    end
  endtask

  task automatic step(input bit v, input logic [12:0] y, input bit rdy, input bit c);
    in_valid  = v;
    in_y      = y;
    out_ready = rdy;
    clr       = c;
    @(posedge clk);
    model_update(v, y, rdy, c);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    rst       = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_acc = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1 rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    chk("lit_rst_valid", int'(out_valid), 0);
    chk("lit_rst_data", int'(out_data), 0);
    chk("lit_rst_count", int'(count), 0);
    chk("lit_rst_ovf", int'(overflow), 0);
    chk("lit_rst_acc", int'(acc), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 13'd0, 1'b0, 1'b0);
    chk("lit_idle_valid", int'(out_valid), 0);

    // Conversion, one sample per cycle with the consumer always ready.
    step(1'b1, 13'h0800, 1'b1, 1'b0);
    chk("lit_conv_2048", int'($signed(out_data)), 2048);
    step(1'b1, 13'h1800, 1'b1, 1'b0);
    chk("lit_conv_m2048", int'($signed(out_data)), -2048);
    step(1'b1, 13'h1000, 1'b1, 1'b0);
    chk("lit_conv_negzero", int'($signed(out_data)), 0);
    chk("lit_conv_negzero_valid", int'(out_valid), 1);
    step(1'b1, 13'h0FFF, 1'b1, 1'b0);
    chk("lit_conv_4095", int'($signed(out_data)), 4095);
    step(1'b0, 13'd0, 1'b1, 1'b0);
    chk("lit_conv_empty", int'(count), 0);

    // Overflow: ten pushes into eight slots, then drain.
    for (int i = 1; i <= 10; i++) step(1'b1, 13'(i), 1'b0, 1'b0);
    chk("lit_ovf_count", int'(count), 8);
    chk("lit_ovf_flag", int'(overflow), 1);
    for (int i = 1; i <= 8; i++) begin
      chk("lit_drain_order", int'($signed(out_data)), i);
      step(1'b0, 13'd0, 1'b1, 1'b0);
    end
    chk("lit_drain_count", int'(count), 0);
    chk("lit_drain_ovf_sticky", int'(overflow), 1);
    step(1'b0, 13'd0, 1'b0, 1'b1);
    chk("lit_clr_ovf", int'(overflow), 0);

    // Simultaneous push and pop while full, across pointer wrap.
    for (int i = 1; i <= 8; i++) step(1'b1, 13'(20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("lit_full_head", int'($signed(out_data)), 21 + i);
      step(1'b1, 13'(40 + i), 1'b1, 1'b0);
      chk("lit_full_count", int'(count), 8);
      chk("lit_full_ovf", int'(overflow), 0);
    end
    chk("lit_full_head_after", int'($signed(out_data)), 26);
    for (int i = 0; i < 8; i++) step(1'b0, 13'd0, 1'b1, 1'b0);

    // clr wins over a same-cycle push.
    for (int i = 1; i <= 10; i++) step(1'b1, 13'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 13'd0, 1'b1, 1'b0);
    chk("lit_pre_clr_count", int'(count), 5);
    chk("lit_pre_clr_ovf", int'(overflow), 1);
    step(1'b1, 13'd5, 1'b0, 1'b1);
    chk("lit_clr_count", int'(count), 0);
    chk("lit_clr_ovf2", int'(overflow), 0);
    chk("lit_clr_acc", int'(acc), 0);
    chk("lit_clr_valid", int'(out_valid), 0);

    // Accumulator saturation and recovery.
    for (int i = 0; i < 200; i++) step(1'b1, 13'h0FFF, 1'b1, 1'b0);
`ifdef RESULT_ACC_EN
    chk("lit_acc_sat", int'($signed(acc)), 524287);
    step(1'b1, 13'h1FFF, 1'b1, 1'b0);
    chk("lit_acc_back", int'($signed(acc)), 520192);
`else
    chk("lit_acc_off", int'($signed(acc)), 0);
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 13'd0, 1'b1, 1'b0);

    // Reset in the middle of a burst.
    for (int i = 0; i < 4; i++) step(1'b1, 13'(100 + i), 1'b0, 1'b0);
    do_reset();
    chk("lit_midrst_count", int'(count), 0);
    chk("lit_midrst_valid", int'(out_valid), 0);
    step(1'b0, 13'd0, 1'b1, 1'b0);
    chk("lit_midrst_after", int'(count), 0);

    // Random traffic with varying consumer duty to visit full and empty.
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 100);
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 3) != 0,
             13'($urandom),
             $urandom_range(1, 100) <= rdy_pct,
             $urandom_range(0, 99) == 0);
      end
      if (blk % 5 == 4) do_reset();
    end

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
